sram_arb: RTL

SRAM_ARB -- requirements
Module: sram_arb

---
 rtl/hwpe_pkg.sv | 30 +++
 rtl/sram_arb_rr.sv | 36 +++
 rtl/sram_arb.sv | 131 +++++++++++++
 3 files changed

// File: rtl/hwpe_pkg.sv
// Shared HWPE definitions: data width, requester limit, sram command record and helpers.
// The address width normally comes from hwpe_define.vh; a 16-bit fallback keeps standalone builds working.
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 16
`endif

package hwpe_pkg;

  localparam int DATA_W  = 64;
  localparam int MAX_REQ = 4;
  localparam int OWNER_W = $clog2(MAX_REQ);
  localparam int ADDR_W  = `SRAM_ADDR_WIDTH;

  typedef struct packed {
    logic               wen;
    logic [ADDR_W-1:0]  addr;
    logic [DATA_W-1:0]  wdata;
    logic [OWNER_W-1:0] owner;
  } cmd_t;

  function automatic logic [OWNER_W-1:0] onehot_to_idx(input logic [MAX_REQ-1:0] oh);
    logic [OWNER_W-1:0] idx;
    idx = '0;
    for (int i = 0; i < MAX_REQ; i++) begin
      if (oh[i]) idx = OWNER_W'(i);
    end
    return idx;
  endfunction

endpackage

// File: rtl/sram_arb_rr.sv
// Grant picker: one-hot grant to the first valid requester at or after ptr_i, wrapping to 0.
// Purely combinational, no backpressure of its own; fixpri_i lets requester 0 pre-empt the rotation.
module sram_arb_rr
  import hwpe_pkg::*;
#(
  parameter int NUM_REQ = 3
) (
  input  logic [NUM_REQ-1:0] valid_i,
  input  logic [OWNER_W-1:0] ptr_i,
  input  logic               fixpri_i,
  output logic [NUM_REQ-1:0] gnt_o
);

  logic [NUM_REQ-1:0] hi_mask;
  logic [NUM_REQ-1:0] hi_valid;
  logic [NUM_REQ-1:0] pick_src;

  always_comb begin
    hi_mask = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      hi_mask[i] = (i >= int'(ptr_i));
    end
  end

  // Prefer requesters at or above the pointer; fall back to the bottom of the vector on wrap.
  assign hi_valid = valid_i & hi_mask;
  assign pick_src = (|hi_valid) ? hi_valid : valid_i;

  always_comb begin
    gnt_o = pick_src & (~pick_src + NUM_REQ'(1));
    if (fixpri_i && valid_i[0]) begin
      gnt_o = NUM_REQ'(1);
    end
  end

endmodule

// File: rtl/sram_arb.sv
// N-way arbiter onto one sram port: grant in cycle T, sram access in T+1, read response in T+2.
// No response backpressure; define SRAM_ARB_FIXPRI_EN to make requester 0 strict-priority.
`ifndef SRAM_ADDR_WIDTH
`define SRAM_ADDR_WIDTH 16
`endif

module sram_arb
  import hwpe_pkg::*;
#(
  parameter int NUM_REQ = 3,
  parameter int AW      = `SRAM_ADDR_WIDTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      arb_en,
  input  logic [NUM_REQ-1:0]        req_valid,
  output logic [NUM_REQ-1:0]        req_ready,
  input  logic [NUM_REQ-1:0]        req_wen,
  input  logic [NUM_REQ*AW-1:0]     req_addr,
  input  logic [NUM_REQ*DATA_W-1:0] req_wdata,
  output logic [NUM_REQ-1:0]        rsp_valid,
  output logic [DATA_W-1:0]         rsp_rdata,
  output logic                      sram_cen,
  output logic                      sram_wen,
  output logic [AW-1:0]             sram_ad,
  output logic [DATA_W-1:0]         sram_wd,
  input  logic [DATA_W-1:0]         sram_rd,
  output logic                      busy
);

`ifdef SRAM_ARB_FIXPRI_EN
  localparam logic FIXPRI = 1'b1;
`else
  localparam logic FIXPRI = 1'b0;
`endif

  logic [OWNER_W-1:0] rr_ptr_q, rr_ptr_d;
  logic               cmd_vld_q, cmd_vld_d;
  cmd_t               cmd_q, cmd_d;
  logic [NUM_REQ-1:0] rsp_vld_q, rsp_vld_d;
  logic [DATA_W-1:0]  rsp_rdata_q, rsp_rdata_d;

  logic [NUM_REQ-1:0] arb_valid;
  logic [NUM_REQ-1:0] gnt;
  logic [OWNER_W-1:0] gnt_idx;
  logic               accept;
  logic               sel_wen;
  logic [AW-1:0]      sel_addr;
  logic [DATA_W-1:0]  sel_wdata;

  // Reset masks the grant so req_ready is low for the whole reset window.
  assign arb_valid = req_valid & {NUM_REQ{arb_en & rst_n}};

  sram_arb_rr #(
    .NUM_REQ (NUM_REQ)
  ) u_rr (
    .valid_i  (arb_valid),
    .ptr_i    (rr_ptr_q),
    .fixpri_i (FIXPRI),
    .gnt_o    (gnt)
  );

  assign req_ready = gnt;
  assign accept    = |gnt;
  assign gnt_idx   = onehot_to_idx(MAX_REQ'(gnt));

  always_comb begin
    sel_wen   = 1'b0;
    sel_addr  = '0;
    sel_wdata = '0;
    for (int i = 0; i < NUM_REQ; i++) begin
      if (gnt[i]) begin
        sel_wen   = req_wen[i];
        sel_addr  = req_addr[i*AW +: AW];
        sel_wdata = req_wdata[i*DATA_W +: DATA_W];
      end
    end
  end

  always_comb begin
    rr_ptr_d  = rr_ptr_q;
    cmd_vld_d = accept;
    cmd_d     = '0;
    if (accept) begin
      cmd_d.wen   = sel_wen;
      cmd_d.addr  = ADDR_W'(sel_addr);
      cmd_d.wdata = sel_wdata;
      cmd_d.owner = gnt_idx;
      // A priority win by requester 0 does not disturb the rotation among the others.
      if (!(FIXPRI && gnt_idx == '0)) begin
        rr_ptr_d = (gnt_idx == OWNER_W'(NUM_REQ - 1)) ? '0 : gnt_idx + OWNER_W'(1);
      end
    end
  end

  always_comb begin
    rsp_vld_d   = '0;
    rsp_rdata_d = rsp_rdata_q;
    if (cmd_vld_q && !cmd_q.wen) begin
      rsp_vld_d   = NUM_REQ'(1) << cmd_q.owner;
      rsp_rdata_d = sram_rd;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rr_ptr_q    <= '0;
      cmd_vld_q   <= 1'b0;
      cmd_q       <= '0;
      rsp_vld_q   <= '0;
      rsp_rdata_q <= '0;
    end else begin
      rr_ptr_q    <= rr_ptr_d;
      cmd_vld_q   <= cmd_vld_d;
      cmd_q       <= cmd_d;
      rsp_vld_q   <= rsp_vld_d;
      rsp_rdata_q <= rsp_rdata_d;
    end
  end

  // cmd_q is zeroed whenever no command is accepted, so idle cycles drive all-zero sram pins.
  assign sram_cen  = cmd_vld_q;
  assign sram_wen  = cmd_q.wen;
  assign sram_ad   = AW'(cmd_q.addr);
  assign sram_wd   = cmd_q.wdata;

  assign rsp_valid = rsp_vld_q;
  assign rsp_rdata = rsp_rdata_q;
  assign busy      = cmd_vld_q | (|rsp_vld_q);

endmodule
